axi_llc_way_arbiter: RTL and testbench

//  Shares the data-way storage between the LLC units (evict, refill, R-chan, W-chan) that issue
//  way_inp requests. Picks one request per cycle, captures it in a one-entry output register and

---
 rtl/axi_llc_pkg.sv | 38 +++
 rtl/axi_llc_way_arb_sel.sv | 68 ++++++
 rtl/axi_llc_way_arbiter.sv | 103 ++++++++++
 tb/tb_axi_llc_way_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
// Shared LLC types and constants used by the data-way arbiter.
//   cache_unit_e : requester identity; its value is also the arbiter input index.
//   llc_cfg_t    : cache geometry (the arbiter only uses SetAssociativity).
//   way_inp_t    : data-way request payload routed to the way macros.
package axi_llc_pkg;

   typedef enum logic [1:0] {
      EvictUnit = 2'd0,
      RefilUnit = 2'd1,
      RChanUnit = 2'd2,
      WChanUnit = 2'd3
   } cache_unit_e;

   localparam int unsigned NumWayReq = 4;

   typedef struct packed {
      int unsigned SetAssociativity;
      int unsigned NumLines;
      int unsigned NumBlocks;
   } llc_cfg_t;

   localparam llc_cfg_t DefaultCfg = '{
      SetAssociativity: 32'd4,
      NumLines:         32'd256,
      NumBlocks:        32'd4
   };

   typedef struct packed {
      cache_unit_e cache_unit;
      logic [3:0]  way_ind;      // one-hot target way
      logic [7:0]  line_addr;
      logic [1:0]  blk_offset;
      logic        we;
      logic [63:0] data;
      logic [7:0]  strb;
   } way_inp_t;

endpackage

// File: rtl/axi_llc_way_arb_sel.sv
// Combinational grant selection for the way arbiter.
//   valid   : request valid per requester
//   starve  : requester has waited the full starvation budget (implies valid)
//   rr_ptr  : round-robin start index
//   gnt_oh  : one-hot grant (zero when nothing is valid)
//   gnt_idx : binary grant index
//   gnt_rr  : grant was decided by the round-robin rule (pointer must advance)
module axi_llc_way_arb_sel import axi_llc_pkg::*; #(
   parameter int unsigned NumReq   = NumWayReq,
   parameter int unsigned RefilIdx = 1,
   localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] valid,
   input  logic [NumReq-1:0] starve,
   input  logic [IdxW-1:0]   rr_ptr,
   output logic [NumReq-1:0] gnt_oh,
   output logic [IdxW-1:0]   gnt_idx,
   output logic              gnt_rr
);

   logic            starve_hit, rr_hit;
   logic [IdxW-1:0] starve_idx, rr_idx;
   int              j;

   // Lowest starving index: scan downwards so the last hit is the lowest.
   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (starve[IdxW'(i)]) begin
            starve_hit = 1'b1;
            starve_idx = IdxW'(i);
         end
      end
   end

   // First valid at or above rr_ptr, wrapping; scanning the rotated offset
   // downwards leaves the smallest offset as the winner.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      j      = 0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= int'(NumReq)) j = j - int'(NumReq);
         if (valid[IdxW'(j)]) begin
            rr_hit = 1'b1;
            rr_idx = IdxW'(j);
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      gnt_rr  = 1'b0;
      gnt_oh  = '0;
      if (starve_hit) begin
         gnt_idx = starve_idx;
      end else if (valid[RefilIdx]) begin
         gnt_idx = IdxW'(RefilIdx);
      end else if (rr_hit) begin
         gnt_idx = rr_idx;
         gnt_rr  = 1'b1;
      end
      if (|valid) gnt_oh[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// Data-way arbiter: one request per cycle from the LLC units into a one-entry
// output register, routed to the way named by the payload's one-hot way_ind.
//   clk_i/rst_ni     : clock, async active-low reset
//   req_i/req_valid_i: per-requester payload and valid
//   req_ready_o      : per-requester accept (at most one high)
//   way_inp_o        : registered payload broadcast to all ways
//   way_inp_valid_o  : per-way valid; way_inp_ready_i : per-way ready
//   err_o            : one-cycle pulse, a request with an illegal way_ind was dropped
// Priority: starving requester, then refill, then round-robin.
module axi_llc_way_arbiter #(
   parameter axi_llc_pkg::llc_cfg_t Cfg = axi_llc_pkg::DefaultCfg,
   parameter type way_inp_t             = axi_llc_pkg::way_inp_t,
   parameter int unsigned NumReq        = axi_llc_pkg::NumWayReq,
   parameter int unsigned RefilIdx      = 32'(axi_llc_pkg::RefilUnit),
   parameter int unsigned StarveCycles  = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  way_inp_t [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]                 req_valid_i,
   output logic [NumReq-1:0]                 req_ready_o,
   output way_inp_t                          way_inp_o,
   output logic [Cfg.SetAssociativity-1:0]   way_inp_valid_o,
   input  logic [Cfg.SetAssociativity-1:0]   way_inp_ready_i,
   output logic                              err_o
);

   localparam int unsigned NumWays = Cfg.SetAssociativity;
   localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned CntW    = $clog2(StarveCycles + 1);

   logic                 full_q, err_q;
   logic [IdxW-1:0]      rr_ptr_q;
   logic [CntW-1:0]      cnt_q [NumReq];
   way_inp_t             way_inp_q;

   logic [NumReq-1:0]    starve, gnt_oh;
   logic [IdxW-1:0]      gnt_idx;
   logic                 gnt_rr, drain, can_load, hs, way_ok;
   logic [NumWays-1:0]   gnt_way;

   axi_llc_way_arb_sel #(
      .NumReq   (NumReq),
      .RefilIdx (RefilIdx)
   ) i_sel (
      .valid   (req_valid_i),
      .starve  (starve),
      .rr_ptr  (rr_ptr_q),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_rr  (gnt_rr)
   );

   // Per-way routing of the held request.
   for (genvar w = 0; w < NumWays; w++) begin : g_way
      assign way_inp_valid_o[w] = full_q & way_inp_q.way_ind[w];
   end

   assign drain       = |(way_inp_valid_o & way_inp_ready_i);
   assign can_load    = ~full_q | drain;
   assign req_ready_o = gnt_oh & {NumReq{can_load}};
   assign hs          = |req_ready_o;

   // One-hot check on the granted payload; illegal requests are accepted but dropped.
   assign gnt_way = req_i[gnt_idx].way_ind;
   assign way_ok  = (gnt_way != '0) && ((gnt_way & (gnt_way - NumWays'(1))) == '0);

   assign way_inp_o = way_inp_q;
   assign err_o     = err_q;

   // Starvation counters: count cycles spent valid but not accepted.
   for (genvar i = 0; i < NumReq; i++) begin : g_req
      assign starve[i] = req_valid_i[i] & (cnt_q[i] == CntW'(StarveCycles));

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q[i] <= '0;
         end else if (!req_valid_i[i] || req_ready_o[i]) begin
            cnt_q[i] <= '0;
         end else if (cnt_q[i] != CntW'(StarveCycles)) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q    <= 1'b0;
         err_q     <= 1'b0;
         rr_ptr_q  <= '0;
         way_inp_q <= '0;
      end else begin
         full_q <= (hs & way_ok) | (full_q & ~drain);
         err_q  <= hs & ~way_ok;
         if (hs & way_ok) way_inp_q <= req_i[gnt_idx];
         // Only round-robin grants move the pointer.
         if (hs & gnt_rr) begin
            rr_ptr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
module tb_axi_llc_way_arbiter;
   import axi_llc_pkg::*;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SC = 16;

   logic                 clk = 1'b0;
   logic                 rst_ni = 1'b0;
   way_inp_t [N-1:0]     req_i;
   logic [N-1:0]         req_valid_i;
   logic [N-1:0]         req_ready_o;
   way_inp_t             way_inp_o;
   logic [W-1:0]         way_inp_valid_o;
   logic [W-1:0]         way_inp_ready_i;
   logic                 err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_llc_way_arbiter dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .req_i           (req_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .way_inp_o       (way_inp_o),
      .way_inp_valid_o (way_inp_valid_o),
      .way_inp_ready_i (way_inp_ready_i),
      .err_o           (err_o)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   way_inp_t m_pay  = '0;
   bit       m_full = 1'b0;
   bit       m_err  = 1'b0;
   int       m_rr   = 0;
   int       m_wait [N];

   int           g;
   bit           by_rr, cl, acc, legal, drained;
   logic [N-1:0] er;

   always @(negedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_pay = '0; m_full = 1'b0; m_err = 1'b0; m_rr = 0;
         for (int i = 0; i < N; i++) m_wait[i] = 0;
      end else begin
         g = -1; by_rr = 1'b0;
         for (int i = 0; i < N; i++)
            if (g < 0 && req_valid_i[i] && m_wait[i] >= SC) g = i;
         if (g < 0 && req_valid_i[int'(RefilUnit)]) g = int'(RefilUnit);
         if (g < 0)
            for (int k = 0; k < N; k++)
               if (g < 0 && req_valid_i[(m_rr + k) % N]) begin
                  g = (m_rr + k) % N; by_rr = 1'b1;
               end
         drained = m_full && ((m_pay.way_ind & way_inp_ready_i) != 4'b0);
         cl = !m_full || drained;
         er = '0;
         if (g >= 0 && cl) er[g] = 1'b1;

         chk("req_ready", 128'(req_ready_o), 128'(er));
         chk("way_valid", 128'(way_inp_valid_o), 128'(m_full ? m_pay.way_ind : 4'b0));
         chk("payload", 128'(way_inp_o), 128'(m_pay));
         chk("err", 128'(err_o), 128'(m_err));

         acc   = (er != '0);
         legal = acc && ($countones(req_i[acc ? g : 0].way_ind) == 1);
         for (int i = 0; i < N; i++) begin
            if (!req_valid_i[i] || (acc && g == i)) m_wait[i] = 0;
            else if (m_wait[i] < SC) m_wait[i]++;
         end
         if (acc && by_rr) m_rr = (g + 1) % N;
         m_err = acc && !legal;
         if (acc && legal) begin
            m_pay = req_i[g]; m_full = 1'b1;
         end else if (drained) begin
            m_full = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   way_inp_t     pay [N];
   bit           pend [N];
   logic [N-1:0] rdy_s;
   way_inp_t     hold;
   int           t3_exp [6] = '{0, 2, 3, 0, 2, 3};

   function automatic way_inp_t mk(input int u, input logic [3:0] wi);
      way_inp_t p;
      p.cache_unit = cache_unit_e'(u);
      p.way_ind    = wi;
      p.line_addr  = 8'($urandom);
      p.blk_offset = 2'($urandom);
      p.we         = 1'($urandom);
      p.data       = {$urandom, $urandom};
      p.strb       = 8'($urandom);
      return p;
   endfunction

   function automatic logic [3:0] rand_way();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 4'b0000;
      if (r == 1) return 4'b1010;
      return 4'(1 << $urandom_range(0, 3));
   endfunction

   function automatic int oh2i(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid_i[i] = pend[i];
         req_i[i]       = pend[i] ? pay[i] : '0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      rdy_s = req_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (rdy_s[i]) pend[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      drive();
      repeat (n) tick();
   endtask

   initial begin
      req_valid_i     = '0;
      req_i           = '0;
      way_inp_ready_i = '1;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_ready", 128'(req_ready_o), 128'(0));
      chk("rst_valid", 128'(way_inp_valid_o), 128'(0));
      chk("rst_err", 128'(err_o), 128'(0));
      rst_ni = 1'b1;
      #1;

      // Single refill request
      pay[1] = mk(1, 4'b0010); pend[1] = 1'b1; hold = pay[1];
      drive(); #1;
      chk("t1_ready", 128'(req_ready_o), 128'(4'b0010));
      tick(); drive(); #1;
      chk("t1_valid", 128'(way_inp_valid_o), 128'(4'b0010));
      chk("t1_payload", 128'(way_inp_o), 128'(hold));
      idle(2);

      // Round-robin order among 0,2,3
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++)
            if (i != 1 && !pend[i]) begin pay[i] = mk(i, 4'(1 << i)); pend[i] = 1'b1; end
         drive(); #1;
         chk("t3_order", 128'(oh2i(req_ready_o)), 128'(t3_exp[k]));
         tick();
      end
      idle(2);

      // All four valid: refill for 16 cycles, then requester 0 forced
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i]) begin pay[i] = mk(i, 4'(1 << $urandom_range(0, 3))); pend[i] = 1'b1; end
         drive(); #1;
         if (k < 16) chk("t2_refill", 128'(oh2i(req_ready_o)), 128'(1));
         else if (k == 16) chk("t2_starve", 128'(oh2i(req_ready_o)), 128'(0));
         tick();
      end
      idle(2);

      // Output held while ways not ready, then drain+load with no bubble
      way_inp_ready_i = '0;
      pay[2] = mk(2, 4'b0100); pend[2] = 1'b1; hold = pay[2];
      drive(); tick();
      pay[0] = mk(0, 4'b0001); pend[0] = 1'b1;
      drive();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_hold_valid", 128'(way_inp_valid_o), 128'(4'b0100));
         chk("t4_hold_payload", 128'(way_inp_o), 128'(hold));
         chk("t4_hold_ready", 128'(req_ready_o), 128'(0));
         tick(); drive();
      end
      way_inp_ready_i = '1;
      #1;
      chk("t4_drain_load", 128'(req_ready_o), 128'(4'b0001));
      for (int k = 0; k < 4; k++) begin
         tick();
         if (!pend[0]) begin pay[0] = mk(0, 4'b0001); pend[0] = 1'b1; end
         drive(); #1;
         chk("t4_stream_ready", 128'(req_ready_o), 128'(4'b0001));
         chk("t4_stream_valid", 128'(way_inp_valid_o), 128'(4'b0001));
      end
      idle(2);

      // Illegal way_ind values
      pay[3] = mk(3, 4'b0000); pend[3] = 1'b1;
      drive(); #1;
      chk("t5_ready0", 128'(req_ready_o), 128'(4'b1000));
      tick();
      pay[3] = mk(3, 4'b0110); pend[3] = 1'b1;
      drive(); #1;
      chk("t5_err0", 128'(err_o), 128'(1));
      chk("t5_valid0", 128'(way_inp_valid_o), 128'(0));
      chk("t5_ready1", 128'(req_ready_o), 128'(4'b1000));
      tick(); drive(); #1;
      chk("t5_err1", 128'(err_o), 128'(1));
      chk("t5_valid1", 128'(way_inp_valid_o), 128'(0));
      tick(); #1;
      chk("t5_err_clr", 128'(err_o), 128'(0));
      idle(1);

      // Reset while holding a request
      way_inp_ready_i = '0;
      pay[2] = mk(2, 4'b1000); pend[2] = 1'b1;
      drive(); tick(); drive(); #1;
      chk("t6_full", 128'(way_inp_valid_o), 128'(4'b1000));
      #2;
      rst_ni = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      drive(); #1;
      chk("t6_rst_valid", 128'(way_inp_valid_o), 128'(0));
      chk("t6_rst_ready", 128'(req_ready_o), 128'(0));
      tick(); tick();
      rst_ni = 1'b1;
      way_inp_ready_i = '1;
      pay[2] = mk(2, 4'b0001); pend[2] = 1'b1;
      pay[3] = mk(3, 4'b0010); pend[3] = 1'b1;
      drive(); #1;
      chk("t6_rr_reset", 128'(req_ready_o), 128'(4'b0100));
      tick();
      idle(2);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int w = 0; w < W; w++) way_inp_ready_i[w] = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, (i == 1) ? 4 : 2) == 0) begin
               pay[i] = mk(i, rand_way()); pend[i] = 1'b1;
            end
         drive();
         tick();
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
